// File: rtl/mem_burst_ctl.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_ctl
// Brief    : Byte-serial RAM controller; LSB loads/stores and I-cache line
//            fills share the 8-bit RAM port. Optional fetch abort: MEMCTL_FLUSH_EN
// Revision : 1.0 - initial release
// ============================================================================
module mem_burst_ctl #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    lsb_req,
  input  logic                    lsb_we,
  input  logic [1:0]              lsb_size,
  input  logic [ADDR_W-1:0]       lsb_addr,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_gnt,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_gnt,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_line,
`ifdef MEMCTL_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr
);

  localparam int c_OFF_W  = $clog2(LINE_BYTES);
  localparam int c_CNT_W  = c_OFF_W + 1;
  localparam int c_LINE_W = 8 * LINE_BYTES;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_FETCH = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [c_CNT_W-1:0]  r_k, w_k_next;
  logic [c_CNT_W-1:0]  r_len, w_len_next;
  logic [ADDR_W-1:0]   r_base, w_base_next;
  logic [ADDR_W-1:0]   r_mem_a, w_mem_a_next;
  logic [31:0]         r_wdata, w_wdata_next;
  logic [31:0]         r_lsb_rdata, w_lsb_rdata_next;
  logic [c_LINE_W-1:0] r_buf, w_buf_next, w_buf_cap;
  logic [c_LINE_W-1:0] r_if_line, w_if_line_next;
  logic [7:0]          r_mem_dout, w_mem_dout_next;
  logic                r_mem_wr, w_mem_wr_next;
  logic                r_lsb_done, w_lsb_done_next;
  logic                r_if_done, w_if_done_next;
  logic                r_resume, w_resume_next;
  logic                w_flush;
  logic                w_idle;
  logic [c_OFF_W-1:0]  w_cap_idx;
  logic [c_CNT_W-1:0]  w_lsb_len;
  logic [ADDR_W-1:0]   w_if_base;
  logic                w_unused_if_off;

`ifdef MEMCTL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_idle  = (r_state == S_IDLE) && rdy;
  assign lsb_gnt = w_idle && lsb_req;
  assign if_gnt  = w_idle && if_req && !lsb_req && !w_flush;

  assign mem_a     = r_mem_a;
  assign mem_dout  = r_mem_dout;
  assign mem_wr    = r_mem_wr && rdy;
  assign lsb_done  = r_lsb_done;
  assign lsb_rdata = r_lsb_rdata;
  assign if_done   = r_if_done;
  assign if_line   = r_if_line;

  assign w_if_base       = {if_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
  assign w_unused_if_off = ^if_addr[c_OFF_W-1:0];

  // Byte k-1 is the one whose read data is on mem_din at edge e_k
  assign w_cap_idx = c_OFF_W'(r_k - c_CNT_W'(1));

  always_comb begin
    w_buf_cap = r_buf;
    w_buf_cap[8*int'(w_cap_idx) +: 8] = mem_din;
  end

  always_comb begin
    unique case (lsb_size)
      2'd0:    w_lsb_len = c_CNT_W'(1);
      2'd1:    w_lsb_len = c_CNT_W'(2);
      default: w_lsb_len = c_CNT_W'(4);
    endcase
  end

  // A stall may let the RAM read pipeline drift, so the first edge after it
  // re-presents the pending address instead of capturing.
  always_comb begin
    w_resume_next = 1'b0;
    if (!rdy) begin
      w_resume_next = (r_state == S_LOAD) || (r_state == S_FETCH);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_k_next         = r_k;
    w_len_next       = r_len;
    w_base_next      = r_base;
    w_wdata_next     = r_wdata;
    w_buf_next       = r_buf;
    w_mem_a_next     = r_mem_a;
    w_mem_dout_next  = r_mem_dout;
    w_mem_wr_next    = r_mem_wr;
    w_lsb_done_next  = r_lsb_done;
    w_if_done_next   = r_if_done;
    w_lsb_rdata_next = r_lsb_rdata;
    w_if_line_next   = r_if_line;
    if (rdy) begin
      w_lsb_done_next = 1'b0;
      w_if_done_next  = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (lsb_gnt) begin
            w_state_next  = lsb_we ? S_STORE : S_LOAD;
            w_base_next   = lsb_addr;
            w_len_next    = w_lsb_len;
            w_wdata_next  = lsb_wdata;
            w_buf_next    = '0;
            w_k_next      = c_CNT_W'(1);
            w_mem_a_next  = lsb_addr;
            w_mem_wr_next = lsb_we;
            if (lsb_we) begin
              w_mem_dout_next = lsb_wdata[7:0];
            end
          end else if (if_gnt) begin
            w_state_next  = S_FETCH;
            w_base_next   = w_if_base;
            w_len_next    = c_CNT_W'(LINE_BYTES);
            w_buf_next    = '0;
            w_k_next      = c_CNT_W'(1);
            w_mem_a_next  = w_if_base;
            w_mem_wr_next = 1'b0;
          end
        end
        S_STORE: begin
          if (r_k == r_len) begin
            w_mem_wr_next   = 1'b0;
            w_lsb_done_next = 1'b1;
            w_state_next    = S_IDLE;
          end else begin
            w_mem_a_next    = r_base + ADDR_W'(r_k);
            w_mem_dout_next = r_wdata[8*int'(r_k[1:0]) +: 8];
            w_k_next        = r_k + c_CNT_W'(1);
          end
        end
        S_LOAD, S_FETCH: begin
          if ((r_state == S_FETCH) && w_flush) begin
            w_state_next  = S_IDLE;
            w_mem_wr_next = 1'b0;
          end else if (r_resume) begin
            w_mem_a_next = r_base + ADDR_W'(w_cap_idx);
          end else begin
            w_buf_next = w_buf_cap;
            if (r_k == r_len) begin
              w_state_next = S_IDLE;
              if (r_state == S_LOAD) begin
                w_lsb_done_next  = 1'b1;
                w_lsb_rdata_next = w_buf_cap[31:0];
              end else begin
                w_if_done_next = 1'b1;
                w_if_line_next = w_buf_cap;
              end
            end else begin
              w_mem_a_next = r_base + ADDR_W'(r_k);
              w_k_next     = r_k + c_CNT_W'(1);
            end
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_len       <= '0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_mem_a     <= '0;
      r_mem_dout  <= '0;
      r_mem_wr    <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_done   <= 1'b0;
      r_lsb_rdata <= '0;
      r_if_line   <= '0;
      r_resume    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_k         <= w_k_next;
      r_len       <= w_len_next;
      r_base      <= w_base_next;
      r_wdata     <= w_wdata_next;
      r_buf       <= w_buf_next;
      r_mem_a     <= w_mem_a_next;
      r_mem_dout  <= w_mem_dout_next;
      r_mem_wr    <= w_mem_wr_next;
      r_lsb_done  <= w_lsb_done_next;
      r_if_done   <= w_if_done_next;
      r_lsb_rdata <= w_lsb_rdata_next;
      r_if_line   <= w_if_line_next;
      r_resume    <= w_resume_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_burst_ctl
// Brief    : Directed self-checking bench for mem_burst_ctl with a byte RAM
//            model and a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_burst_ctl;

  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int LW         = 8 * LINE_BYTES;

  typedef logic [ADDR_W+7:0] wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              lsb_req = 1'b0;
  logic              lsb_we = 1'b0;
  logic [1:0]        lsb_size = 2'd0;
  logic [ADDR_W-1:0] lsb_addr = '0;
  logic [31:0]       lsb_wdata = '0;
  logic              lsb_gnt, lsb_done;
  logic [31:0]       lsb_rdata;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_done;
  logic [LW-1:0]     if_line;
`ifdef MEMCTL_FLUSH_EN
  logic              flush = 1'b0;
`endif
  logic [7:0]        mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  logic [7:0] ram [0:65535];
  wr_t        exp_wr[$];
  wr_t        obs_wr[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         if_done_seen = 0;

  mem_burst_ctl #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_gnt(lsb_gnt), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_line(if_line),
`ifdef MEMCTL_FLUSH_EN
    .flush(flush),
`endif
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM returns the byte at the address registered by the controller
  assign mem_din = ram[mem_a[15:0]];

  always @(negedge clk) begin
    #2;
    if (mem_wr === 1'b1) obs_wr.push_back({mem_a, mem_dout});
    if (if_done === 1'b1) if_done_seen = if_done_seen + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    wr_t e, o;
    check({tag, "_count"}, 128'(obs_wr.size()), 128'(exp_wr.size()));
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      if (obs_wr.size() > 0) o = obs_wr.pop_front();
      else o = '1;
      check(tag, 128'(o), 128'(e));
    end
    obs_wr.delete();
  endtask

  function automatic logic [LW-1:0] build_line(input int base);
    logic [LW-1:0] l;
    for (int i = 0; i < LINE_BYTES; i++) l[8*i +: 8] = ram[base + i];
    return l;
  endfunction

  task automatic issue_lsb(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, output int g);
    int n;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (we) begin
      for (int i = 0; i < n; i++) exp_wr.push_back({addr + 32'(i), wdata[8*i +: 8]});
    end
    lsb_req = 1'b1; lsb_we = we; lsb_size = size; lsb_addr = addr; lsb_wdata = wdata;
    g = -1;
    for (int i = 0; i < 40 && g < 0; i++) begin
      #1;
      if (lsb_gnt === 1'b1) g = cyc;
      @(negedge clk);
    end
    lsb_req = 1'b0;
  endtask

  task automatic issue_if(input logic [31:0] addr, output int g);
    if_req = 1'b1; if_addr = addr;
    g = -1;
    for (int i = 0; i < 40 && g < 0; i++) begin
      #1;
      if (if_gnt === 1'b1) g = cyc;
      @(negedge clk);
    end
    if_req = 1'b0;
  endtask

  task automatic wait_lsb(output int d);
    d = -1;
    for (int i = 0; i < 100 && d < 0; i++) begin
      if (lsb_done === 1'b1) d = cyc;
      else @(negedge clk);
    end
  endtask

  task automatic wait_if(output int d);
    d = -1;
    for (int i = 0; i < 100 && d < 0; i++) begin
      if (if_done === 1'b1) d = cyc;
      else @(negedge clk);
    end
  endtask

  initial begin
    int g, d;
    logic [LW-1:0] last_line;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22;
    ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;
    for (int i = 0; i < 48; i++) ram[16'h1000 + i] = 8'(8'hA0 ^ (i * 13));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mem_wr", 128'(mem_wr), 128'(0));
    check("rst_mem_a", 128'(mem_a), 128'(0));
    check("rst_mem_dout", 128'(mem_dout), 128'(0));
    check("rst_lsb_done", 128'(lsb_done), 128'(0));
    check("rst_if_done", 128'(if_done), 128'(0));
    check("rst_lsb_rdata", 128'(lsb_rdata), 128'(0));
    check("rst_if_line", 128'(if_line), 128'(0));
    @(negedge clk);

    // 4-byte store, then single-cycle done pulse
    issue_lsb(1'b1, 2'd2, 32'h100, 32'hAABBCCDD, g);
    wait_lsb(d);
    check("st4_lat", 128'(d - (g + 1)), 128'(4));
    check_writes("st4_wr");
    @(negedge clk);
    check("st4_pulse", 128'(lsb_done), 128'(0));

    // 2-byte load, zero-extended and held after done
    issue_lsb(1'b0, 2'd1, 32'h200, 32'h0, g);
    wait_lsb(d);
    check("ld2_lat", 128'(d - (g + 1)), 128'(2));
    check("ld2_data", 128'(lsb_rdata), 128'(32'h00002211));
    check_writes("ld2_wr");
    @(negedge clk);
    check("ld2_hold", 128'(lsb_rdata), 128'(32'h00002211));

    issue_lsb(1'b0, 2'd0, 32'h203, 32'h0, g);
    wait_lsb(d);
    check("ld1_lat", 128'(d - (g + 1)), 128'(1));
    check("ld1_data", 128'(lsb_rdata), 128'(32'h00000044));
    @(negedge clk);

    // address wrap and size=3 treated as 4 bytes
    issue_lsb(1'b1, 2'd1, 32'hFFFFFFFF, 32'h00001234, g);
    wait_lsb(d);
    check("wrap_lat", 128'(d - (g + 1)), 128'(2));
    check_writes("wrap_wr");
    @(negedge clk);
    issue_lsb(1'b1, 2'd3, 32'h300, 32'h04030201, g);
    wait_lsb(d);
    check("sz3_lat", 128'(d - (g + 1)), 128'(4));
    check_writes("sz3_wr");
    @(negedge clk);

    // line fill ignores low address bits
    issue_if(32'h1007, g);
    wait_if(d);
    check("fetch_lat", 128'(d - (g + 1)), 128'(16));
    check("fetch_line", 128'(if_line), 128'(build_line(32'h1000)));
    check_writes("fetch_wr");
    @(negedge clk);

    // simultaneous requests: LSB first, fetch granted in the lsb_done cycle
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd1; lsb_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h1013;
    #1;
    check("pri_lsb_gnt", 128'(lsb_gnt), 128'(1));
    check("pri_if_gnt", 128'(if_gnt), 128'(0));
    g = cyc;
    @(negedge clk);
    lsb_req = 1'b0;
    wait_lsb(d);
    check("pri_ld_lat", 128'(d - (g + 1)), 128'(2));
    check("pri_ld_data", 128'(lsb_rdata), 128'(32'h00002211));
    #1;
    check("pri_if_gnt_done", 128'(if_gnt), 128'(1));
    g = cyc;
    @(negedge clk);
    if_req = 1'b0;
    wait_if(d);
    check("pri_fetch_lat", 128'(d - (g + 1)), 128'(16));
    check("pri_fetch_line", 128'(if_line), 128'(build_line(32'h1010)));
    last_line = build_line(32'h1010);
    @(negedge clk);

    // unstalled vs stalled 4-byte load
    issue_lsb(1'b0, 2'd2, 32'h200, 32'h0, g);
    wait_lsb(d);
    check("ld4_lat", 128'(d - (g + 1)), 128'(4));
    check("ld4_data", 128'(lsb_rdata), 128'(32'h44332211));
    @(negedge clk);
    issue_lsb(1'b0, 2'd2, 32'h200, 32'h0, g);
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("stall_mem_a", 128'(mem_a), 128'(32'h202));
      check("stall_mem_wr", 128'(mem_wr), 128'(0));
    end
    rdy = 1'b1;
    wait_lsb(d);
    check("stall_lat", 128'(d - (g + 1)), 128'(8));
    check("stall_data", 128'(lsb_rdata), 128'(32'h44332211));
    @(negedge clk);

    // store stalled for one cycle: mem_wr gated, byte re-driven once
    issue_lsb(1'b1, 2'd2, 32'h400, 32'h55667788, g);
    rdy = 1'b0;
    #1;
    check("st_stall_wr", 128'(mem_wr), 128'(0));
    @(negedge clk);
    rdy = 1'b1;
    wait_lsb(d);
    check("st_stall_lat", 128'(d - (g + 1)), 128'(5));
    check_writes("st_stall_wr");
    @(negedge clk);

    // no grant while frozen
    rdy = 1'b0; lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h200;
    #1;
    check("rdy0_gnt", 128'(lsb_gnt), 128'(0));
    lsb_req = 1'b0; rdy = 1'b1;
    @(negedge clk);

`ifdef MEMCTL_FLUSH_EN
    if_done_seen = 0;
    issue_if(32'h1000, g);
    repeat (5) @(negedge clk);
    #1;
    check("fl_addr", 128'(mem_a), 128'(32'h1005));
    flush = 1'b1;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h200;
    @(negedge clk);
    #1;
    check("fl_lsb_gnt", 128'(lsb_gnt), 128'(1));
    g = cyc;
    @(negedge clk);
    lsb_req = 1'b0; flush = 1'b0;
    wait_lsb(d);
    check("fl_ld_lat", 128'(d - (g + 1)), 128'(1));
    check("fl_ld_data", 128'(lsb_rdata), 128'(32'h00000011));
    check("fl_no_done", 128'(if_done_seen), 128'(0));
    check("fl_line_kept", 128'(if_line), 128'(last_line));
    flush = 1'b1; if_req = 1'b1; if_addr = 32'h1000;
    #1;
    check("fl_if_gnt_masked", 128'(if_gnt), 128'(0));
    flush = 1'b0;
    #1;
    check("fl_if_gnt", 128'(if_gnt), 128'(1));
    g = cyc;
    @(negedge clk);
    if_req = 1'b0;
    wait_if(d);
    check("fl_fetch_lat", 128'(d - (g + 1)), 128'(16));
    check("fl_fetch_line", 128'(if_line), 128'(build_line(32'h1000)));
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
